posit_link_host: RTL and testbench

//  Host-side initiator for the posit ALU chip's byte-serial pin protocol. Takes one

---
 rtl/posit_link_host.sv | 240 ++++++++++++++++++++++++
 tb/tb_posit_link_host.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_link_host.sv
// Host-side initiator for the posit ALU chip byte-serial pin protocol.
// Writes {b,a} as four bytes, reads back echo plus result as six bytes.
module posit_link_host #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RST_PULSE      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_value,
    output logic        res_echo_ok,
    output logic        err_timeout,
    output logic        busy,
    output logic [7:0]  link_data_out,
    output logic        link_wr_valid,
    output logic        link_rd_ack,
    output logic        link_rst_n,
    input  logic [7:0]  link_data_in,
    input  logic        link_alu_ready,
    input  logic        link_rd_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = 8;

    typedef enum logic [2:0] {
        LRST, IDLE, W_WAIT, W_ACK, R_WAIT, R_SAMPLE, R_DROP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] aux_q, aux_d;
    logic [1:0]  wi_q, wi_d;
    logic [2:0]  ri_q, ri_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [7:0]  rbuf_q [0:5];
    logic [7:0]  rbuf_d [0:5];
    logic [1:0]  ar_sync_q, ar_sync_d, rr_sync_q, rr_sync_d;
    logic        op_ready_q, op_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_value_q, res_value_d;
    logic        res_echo_ok_q, res_echo_ok_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        wr_valid_q, wr_valid_d;
    logic        rd_ack_q, rd_ack_d;
    logic        rst_n_q, rst_n_d;
    logic        ar_s, rr_s, waiting;
    logic [31:0] wword;
    logic [7:0]  wbyte;

    assign ar_s  = ar_sync_q[1];
    assign rr_s  = rr_sync_q[1];
    assign wword = {b_q, a_q};
    assign wbyte = wword[{wi_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        tmo_d         = '0;
        aux_d         = aux_q;
        wi_d          = wi_q;
        ri_d          = ri_q;
        a_d           = a_q;
        b_d           = b_q;
        rbuf_d        = rbuf_q;
        ar_sync_d     = {ar_sync_q[0], link_alu_ready};
        rr_sync_d     = {rr_sync_q[0], link_rd_ready};
        op_ready_d    = op_ready_q;
        res_valid_d   = res_valid_q;
        res_value_d   = res_value_q;
        res_echo_ok_d = res_echo_ok_q;
        err_d         = 1'b0;
        busy_d        = busy_q;
        data_out_d    = data_out_q;
        wr_valid_d    = wr_valid_q;
        rd_ack_d      = rd_ack_q;
        rst_n_d       = rst_n_q;
        unique case (state_q)
            LRST: begin
                if (aux_q == AW'(RST_PULSE - 1)) begin
                    aux_d      = '0;
                    rst_n_d    = 1'b1;
                    op_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    aux_d = aux_q + 1'b1;
                end
            end
            IDLE: begin
                if (op_valid) begin
                    a_d           = op_a;
                    b_d           = op_b;
                    wi_d          = '0;
                    op_ready_d    = 1'b0;
                    busy_d        = 1'b1;
                    res_echo_ok_d = 1'b0;
                    state_d       = W_WAIT;
                end
            end
            W_WAIT: begin
                if (ar_s) begin
                    data_out_d = wbyte;
                    wr_valid_d = 1'b1;
                    state_d    = W_ACK;
                end
            end
            W_ACK: begin
                if (!ar_s) begin
                    wr_valid_d = 1'b0;
                    if (wi_q == 2'd3) begin
                        ri_d    = '0;
                        state_d = R_WAIT;
                    end else begin
                        wi_d    = wi_q + 1'b1;
                        state_d = W_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // once rd_ready is seen, aux counts the settle window
                if (rr_s || aux_q != '0) begin
                    if (aux_q == AW'(SETTLE_CYCLES)) begin
                        aux_d   = '0;
                        state_d = R_SAMPLE;
                    end else begin
                        aux_d = aux_q + 1'b1;
                    end
                end
            end
            R_SAMPLE: begin
                rbuf_d[ri_q] = link_data_in;
                rd_ack_d     = 1'b1;
                state_d      = R_DROP;
            end
            R_DROP: begin
                if (!rr_s) begin
                    rd_ack_d = 1'b0;
                    if (ri_q == 3'd5) begin
                        res_valid_d   = 1'b1;
                        res_value_d   = {rbuf_q[5], rbuf_q[4]};
                        res_echo_ok_d = {rbuf_q[3], rbuf_q[2], rbuf_q[1],
                                         rbuf_q[0]} == {b_q, a_q};
                        state_d       = DONE;
                    end else begin
                        ri_d    = ri_q + 1'b1;
                        state_d = R_WAIT;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    op_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = LRST;
        endcase
        waiting = state_q inside {W_WAIT, W_ACK, R_WAIT, R_DROP};
        if (waiting && state_d == state_q) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d      = 1'b1;
                wr_valid_d = 1'b0;
                rd_ack_d   = 1'b0;
                rst_n_d    = 1'b0;
                busy_d     = 1'b0;
                aux_d      = '0;
                state_d    = LRST;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LRST;
            tmo_q         <= '0;
            aux_q         <= '0;
            wi_q          <= '0;
            ri_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rbuf_q        <= '{default: '0};
            ar_sync_q     <= '0;
            rr_sync_q     <= '0;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_value_q   <= '0;
            res_echo_ok_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            data_out_q    <= '0;
            wr_valid_q    <= 1'b0;
            rd_ack_q      <= 1'b0;
            rst_n_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            aux_q         <= aux_d;
            wi_q          <= wi_d;
            ri_q          <= ri_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rbuf_q        <= rbuf_d;
            ar_sync_q     <= ar_sync_d;
            rr_sync_q     <= rr_sync_d;
            op_ready_q    <= op_ready_d;
            res_valid_q   <= res_valid_d;
            res_value_q   <= res_value_d;
            res_echo_ok_q <= res_echo_ok_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            data_out_q    <= data_out_d;
            wr_valid_q    <= wr_valid_d;
            rd_ack_q      <= rd_ack_d;
            rst_n_q       <= rst_n_d;
        end
    end

    assign op_ready      = op_ready_q;
    assign res_valid     = res_valid_q;
    assign res_value     = res_value_q;
    assign res_echo_ok   = res_echo_ok_q;
    assign err_timeout   = err_q;
    assign busy          = busy_q;
    assign link_data_out = data_out_q;
    assign link_wr_valid = wr_valid_q;
    assign link_rd_ack   = rd_ack_q;
    assign link_rst_n    = rst_n_q;

endmodule

// File: tb/tb_posit_link_host.sv
// Bench for posit_link_host: behavioural chip stub (res = a + b) plus
// a scoreboard of expected results and timeouts.
module tb_posit_link_host;

    localparam int TMO = 1024;
    localparam int RPL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0, op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_value;
    logic        res_echo_ok, err_timeout, busy;
    logic [7:0]  link_data_out, link_data_in;
    logic        link_wr_valid, link_rd_ack, link_rst_n;
    logic        link_alu_ready, link_rd_ready;

    posit_link_host #(
        .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TMO), .RST_PULSE(RPL)
    ) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_value(res_value), .res_echo_ok(res_echo_ok),
        .err_timeout(err_timeout), .busy(busy),
        .link_data_out(link_data_out), .link_wr_valid(link_wr_valid),
        .link_rd_ack(link_rd_ack), .link_rst_n(link_rst_n),
        .link_data_in(link_data_in), .link_alu_ready(link_alu_ready),
        .link_rd_ready(link_rd_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- chip stub ----------------
    int   skew_max = 0;
    logic corrupt = 1'b0;
    logic hold = 1'b0;
    int   c_st, dly;
    logic c_ar, c_rr;
    logic [7:0] c_data;
    logic [7:0] cb [0:3];
    logic [7:0] ob [0:5];
    logic [1:0] cw;
    logic [2:0] cr;
    logic wv_m, wv_s, ra_m, ra_s;
    logic [15:0] c_sum;

    assign c_sum = {cb[3], cb[2]} + {cb[1], cb[0]};
    assign link_alu_ready = c_ar & ~hold;
    assign link_rd_ready = c_rr;
    assign link_data_in = c_data;

    always @(posedge clk) begin
        wv_m <= link_wr_valid;
        wv_s <= wv_m;
        ra_m <= link_rd_ack;
        ra_s <= ra_m;
        if (!link_rst_n) begin
            c_st <= 0; dly <= 0; c_ar <= 0; c_rr <= 0;
            c_data <= 0; cw <= 0; cr <= 0;
        end else begin
            case (c_st)
                0: if (dly == 0) begin
                    c_ar <= 1; c_st <= 1;
                end else dly <= dly - 1;
                1: if (wv_s && link_alu_ready) begin
                    cb[cw] <= link_data_out; c_ar <= 0; c_st <= 2;
                end
                2: if (!wv_s) begin
                    dly <= int'($urandom_range(skew_max, 0));
                    if (cw == 2'd3) begin
                        ob[0] <= cb[0]; ob[1] <= cb[1];
                        ob[2] <= corrupt ? 8'h00 : cb[2];
                        ob[3] <= cb[3];
                        ob[4] <= c_sum[7:0]; ob[5] <= c_sum[15:8];
                        cr <= 0; c_st <= 3;
                    end else begin
                        cw <= cw + 1'b1; c_st <= 0;
                    end
                end
                3: if (dly == 0) begin
                    c_data <= ob[cr]; c_rr <= 1; c_st <= 4;
                end else dly <= dly - 1;
                4: if (ra_s) begin
                    c_rr <= 0; c_st <= 5;
                end
                5: if (!ra_s) begin
                    dly <= int'($urandom_range(skew_max, 0));
                    if (cr == 3'd5) begin
                        cw <= 0; c_st <= 0;
                    end else begin
                        cr <= cr + 1'b1; c_st <= 3;
                    end
                end
                default: c_st <= 0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] v;
        logic        echo;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_res = 0;
    int   n_tmo = 0;
    logic overlap = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (link_wr_valid && link_rd_ack) overlap <= 1'b1;
        if (res_valid && res_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("res_not_timeout", 32'(0), 32'(e.to));
                check("res_value", 32'(res_value), 32'(e.v));
                check("res_echo_ok", 32'(res_echo_ok), 32'(e.echo));
            end
        end
        if (err_timeout) begin
            n_tmo++;
            if (exp_q.size() == 0) begin
                check("tmo_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("tmo_expected", 32'(1), 32'(e.to));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic to);
        int k = 0;
        exp_t e;
        while (!op_ready && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check("op_ready_wait", 32'(op_ready), 32'(1));
        op_a = a; op_b = b; op_valid = 1'b1;
        @(posedge clk);
        e.v = a + b; e.echo = ~corrupt; e.to = to;
        exp_q.push_back(e);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!op_ready && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check(tag, 32'(op_ready), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int acks;
        logic prev;
        logic stable;
        logic [15:0] ra, rb, hv;

        repeat (3) @(posedge clk);
        #1;
        check("rst_flags",
              32'({op_ready, res_valid, res_echo_ok, err_timeout, busy,
                   link_wr_valid, link_rd_ack, link_rst_n}), 32'(0));
        check("rst_data", 32'({link_data_out, res_value}), 32'(0));
        rst = 1'b0;
        cnt = 0;
        while (!link_rst_n && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        check("rst_pulse_len", 32'(cnt), 32'(RPL));
        check("rst_op_ready", 32'(op_ready), 32'(1));

        // 1: basic op
        send_op(16'h1234, 16'h0F0F, 1'b0);
        check("busy_after_accept", 32'(busy), 32'(1));
        wait_idle("t1_idle");
        check("wr_bytes", 32'({cb[0], cb[1], cb[2], cb[3]}), 32'h34120F0F);
        check("t1_res_count", 32'(n_res), 32'(1));

        // 2: corrupted echo
        corrupt = 1'b1;
        send_op(16'h1111, 16'h2222, 1'b0);
        wait_idle("t2_idle");
        corrupt = 1'b0;

        // 3: alu_ready held low
        hold = 1'b1;
        send_op(16'hABCD, 16'h0001, 1'b1);
        cnt = 0;
        while (!err_timeout && cnt < 3000) begin
            @(posedge clk); #1; cnt++;
        end
        check("tmo_cycles", 32'(cnt), 32'(TMO));
        check("tmo_pins", 32'({link_wr_valid, link_rd_ack, res_valid}),
              32'(0));
        hold = 1'b0;
        cnt = 0;
        while (!link_rst_n && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        check("tmo_rst_pulse", 32'(cnt), 32'(RPL));
        check("tmo_op_ready", 32'(op_ready), 32'(1));
        repeat (20) @(posedge clk);
        #1 check("tmo_pulses", 32'(n_tmo), 32'(1));

        // 4: back-to-back random ops, random reply skew
        skew_max = 7;
        overlap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send_op(ra, rb, 1'b0);
        end
        wait_idle("t4_idle");
        check("no_overlap", 32'(overlap), 32'(0));
        skew_max = 0;

        // 5: reset during R_DROP of the fourth read byte
        send_op(16'h5555, 16'h0AAA, 1'b0);
        acks = 0; prev = 1'b0; cnt = 0;
        while (acks < 4 && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
            if (link_rd_ack && !prev) acks++;
            prev = link_rd_ack;
        end
        check("t5_reach_ack3", 32'(acks), 32'(4));
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        check("t5_pins_idle",
              32'({link_wr_valid, link_rd_ack, link_rst_n, res_valid}),
              32'(0));
        rst = 1'b0;
        send_op(16'h7000, 16'h0123, 1'b0);
        wait_idle("t5_idle");

        // 6: hold off result consumer
        res_ready = 1'b0;
        send_op(16'h4242, 16'h0101, 1'b0);
        cnt = 0;
        while (!res_valid && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        check("t6_res_valid", 32'(res_valid), 32'(1));
        hv = res_value;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!res_valid || res_value !== hv || op_ready || !busy)
                stable = 1'b0;
        end
        check("t6_stable", 32'(stable), 32'(1));
        check("t6_value", 32'(hv), 32'(16'h4343));
        res_ready = 1'b1;
        wait_idle("t6_idle");
        check("busy_after_done", 32'(busy), 32'(0));

        repeat (5) @(posedge clk);
        #1;
        check("total_results", 32'(n_res), 32'(6));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
